// File: rtl/program_loader.sv
// Serial program loader and writable instruction store: shifts DEPTH words in MSB-first, holds the core in reset until full.
// Optional PROGRAM_LOADER_PARITY_EN: each frame carries a trailing even-parity bit; a bad frame parks the loader in ERR.
module program_loader #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int IW    = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clk_en,
    input  logic          i_load_start,
    input  logic          i_sdi,
    input  logic          i_sdi_valid,
    output logic          o_sdi_ready,
    input  logic [AW-1:0] i_address,
    output logic [IW-1:0] o_data,
    output logic          o_core_reset,
    output logic          o_load_done,
    output logic          o_load_err,
    output logic [AW:0]   o_words_loaded
);

`ifdef PROGRAM_LOADER_PARITY_EN
    localparam int FW = IW + 1;
`else
    localparam int FW = IW;
`endif
    localparam int BCW = $clog2(FW) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WRITE,
        S_RUN,
        S_ERR
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_mem [DEPTH];
    logic [FW-1:0]   r_shift;
    logic [BCW-1:0]  r_bit_cnt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_words;
    logic            r_sdi_ready;
    logic            r_core_reset;
    logic            r_load_done;
    logic            r_load_err;

    logic [IW-1:0]   w_word;
    logic            w_parity_ok;
    logic            w_restart;
    logic            w_bit_accept;
    logic            w_last_bit;
    logic            w_last_word;
    logic            w_words_full;

`ifdef PROGRAM_LOADER_PARITY_EN
    assign w_word      = r_shift[FW-1:1];
    assign w_parity_ok = ~(^r_shift);
`else
    assign w_word      = r_shift;
    assign w_parity_ok = 1'b1;
`endif

    // load_start is only honoured in states where the core is not mid-load
    assign w_restart    = i_load_start &&
                          (r_state == S_IDLE || r_state == S_RUN || r_state == S_ERR);
    assign w_bit_accept = (r_state == S_SHIFT) && i_sdi_valid;
    assign w_last_bit   = (r_bit_cnt == BCW'(FW - 1));
    assign w_last_word  = (r_wr_ptr == AW'(DEPTH - 1));
    assign w_words_full = (r_words == (AW + 1)'(DEPTH));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_words      <= '0;
            r_sdi_ready  <= 1'b0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clk_en) begin
            if (w_restart) begin
                r_state      <= S_SHIFT;
                r_bit_cnt    <= '0;
                r_wr_ptr     <= '0;
                r_words      <= '0;
                r_sdi_ready  <= 1'b1;
                r_core_reset <= 1'b1;
                r_load_done  <= 1'b0;
                r_load_err   <= 1'b0;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        if (w_bit_accept) begin
                            r_shift <= {r_shift[FW-2:0], i_sdi};
                            if (w_last_bit) begin
                                r_bit_cnt   <= '0;
                                r_state     <= S_WRITE;
                                r_sdi_ready <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BCW'(1);
                            end
                        end
                    end
                    S_WRITE: begin
                        if (w_parity_ok) begin
                            r_mem[r_wr_ptr] <= w_word;
                            r_wr_ptr        <= r_wr_ptr + AW'(1);
                            if (!w_words_full) begin
                                r_words <= r_words + (AW + 1)'(1);
                            end
                            if (w_last_word) begin
                                r_state      <= S_RUN;
                                r_core_reset <= 1'b0;
                                r_load_done  <= 1'b1;
                            end else begin
                                r_state     <= S_SHIFT;
                                r_sdi_ready <= 1'b1;
                            end
                        end else begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_data         = r_mem[i_address];
    assign o_sdi_ready    = r_sdi_ready;
    assign o_core_reset   = r_core_reset;
    assign o_load_done    = r_load_done;
    assign o_load_err     = r_load_err;
    assign o_words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: serial loads with a scoreboard of expected store contents.
module tb_program_loader;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int IW    = 2;
`ifdef PROGRAM_LOADER_PARITY_EN
    localparam int FW = IW + 1;
`else
    localparam int FW = IW;
`endif
    localparam int LOAD_LAT = DEPTH * (FW + 1);

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_clk_en;
    logic          i_load_start;
    logic          i_sdi;
    logic          i_sdi_valid;
    logic          o_sdi_ready;
    logic [AW-1:0] i_address;
    logic [IW-1:0] o_data;
    logic          o_core_reset;
    logic          o_load_done;
    logic          o_load_err;
    logic [AW:0]   o_words_loaded;

    int total = 0;
    int bad   = 0;
    bit                q_bits[$];
    logic [AW+IW-1:0]  sb[$];

    program_loader #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_clk_en       (i_clk_en),
        .i_load_start   (i_load_start),
        .i_sdi          (i_sdi),
        .i_sdi_valid    (i_sdi_valid),
        .o_sdi_ready    (o_sdi_ready),
        .i_address      (i_address),
        .o_data         (o_data),
        .o_core_reset   (o_core_reset),
        .o_load_done    (o_load_done),
        .o_load_err     (o_load_err),
        .o_words_loaded (o_words_loaded)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_word(input int addr, input logic [IW-1:0] w);
        for (int b = IW - 1; b >= 0; b--) q_bits.push_back(w[b]);
`ifdef PROGRAM_LOADER_PARITY_EN
        q_bits.push_back(^w);
`endif
        sb.push_back({AW'(addr), w});
    endtask

    task automatic start_load();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
    endtask

    // Feeds queued bits; stalls sdi_valid for 3 cycles from stall_at and clk_en for 2 from ce_at.
    task automatic run_load(input int stall_at, input int ce_at, input logic [IW-1:0] pre_data,
                            input int max_edges, output int rel_done);
        logic core_ok;
        logic data_ok;
        core_ok  = 1'b1;
        data_ok  = 1'b1;
        rel_done = -1;
        for (int rel = 0; rel < max_edges; rel++) begin
            i_clk_en = !(rel >= ce_at && rel < ce_at + 2);
            if (q_bits.size() > 0 && o_sdi_ready && !(rel >= stall_at && rel < stall_at + 3)) begin
                i_sdi_valid = 1'b1;
                i_sdi       = q_bits[0];
            end else begin
                i_sdi_valid = 1'b0;
                i_sdi       = 1'($urandom);
            end
            tick();
            if (i_sdi_valid && i_clk_en) void'(q_bits.pop_front());
            if (o_load_done || o_load_err) begin
                rel_done = rel + 1;
                break;
            end
            if (o_core_reset !== 1'b1) core_ok = 1'b0;
            if (o_data !== pre_data) data_ok = 1'b0;
        end
        i_sdi_valid = 1'b0;
        i_clk_en    = 1'b1;
        chk("core_reset_held", 32'(core_ok), 1);
        chk("data_before_done", 32'(data_ok), 1);
    endtask

    task automatic check_sb();
        logic [AW+IW-1:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            i_address = e[AW+IW-1:IW];
            #1;
            chk("mem_word", 32'(o_data), 32'(e[IW-1:0]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sdi_ready"}, 32'(o_sdi_ready), 0);
        chk({tag, "_core_reset"}, 32'(o_core_reset), 1);
        chk({tag, "_load_done"}, 32'(o_load_done), 0);
        chk({tag, "_load_err"}, 32'(o_load_err), 0);
        chk({tag, "_words"}, 32'(o_words_loaded), 0);
        for (int a = 0; a < DEPTH; a++) begin
            i_address = AW'(a);
            #1;
            chk({tag, "_data"}, 32'(o_data), 0);
        end
    endtask

    initial begin
        int rel;
        i_reset      = 1'b0;
        i_clk_en     = 1'b1;
        i_load_start = 1'b0;
        i_sdi        = 1'b0;
        i_sdi_valid  = 1'b0;
        i_address    = '0;

        // asynchronous reset asserted mid-cycle
        #12 i_reset = 1'b1;
        #1;
        check_reset_outputs("por");
        @(negedge i_clk) i_reset = 1'b0;
        tick();

        // gap-free load
        i_address = 2'd3;
        push_word(0, 2'b01);
        push_word(1, 2'b10);
        push_word(2, 2'b11);
        push_word(3, 2'b00);
        start_load();
        chk("ready_after_start", 32'(o_sdi_ready), 1);
        run_load(1000, 1000, 2'b00, 100, rel);
        chk("latency_gapfree", 32'(rel), 32'(LOAD_LAT));
        chk("done_gapfree", 32'(o_load_done), 1);
        chk("core_reset_run", 32'(o_core_reset), 0);
        chk("ready_run", 32'(o_sdi_ready), 0);
        chk("words_gapfree", 32'(o_words_loaded), 4);
        check_sb();

        // stalls plus clock-enable low: completion slips by 5
        i_address = 2'd3;
        push_word(0, 2'b01);
        push_word(1, 2'b10);
        push_word(2, 2'b11);
        push_word(3, 2'b00);
        start_load();
        run_load(4, 7, 2'b00, 100, rel);
        chk("latency_stall", 32'(rel), 32'(LOAD_LAT + 5));
        chk("words_stall", 32'(o_words_loaded), 4);
        check_sb();

        // reload from RUN
        i_address = 2'd3;
        for (int k = 0; k < DEPTH; k++) push_word(k, 2'b11);
        start_load();
        chk("reload_core_reset", 32'(o_core_reset), 1);
        chk("reload_done_low", 32'(o_load_done), 0);
        chk("reload_words_clr", 32'(o_words_loaded), 0);
        run_load(1000, 1000, 2'b00, 100, rel);
        chk("latency_reload", 32'(rel), 32'(LOAD_LAT));
        chk("reload_addr3", 32'(o_data), 32'(2'b11));
        check_sb();

        // reset after two words written
        i_address = 2'd3;
        push_word(0, 2'b01);
        push_word(1, 2'b10);
        push_word(2, 2'b01);
        push_word(3, 2'b10);
        start_load();
        run_load(1000, 1000, 2'b11, 2 * (FW + 1), rel);
        chk("words_partial", 32'(o_words_loaded), 2);
        #3 i_reset = 1'b1;
        #1;
        check_reset_outputs("midload");
        @(negedge i_clk) i_reset = 1'b0;
        q_bits.delete();
        sb.delete();
        i_sdi_valid = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        i_sdi_valid = 1'b0;
        chk("idle_after_reset", 32'(o_sdi_ready), 0);
        chk("idle_words", 32'(o_words_loaded), 0);

`ifdef PROGRAM_LOADER_PARITY_EN
        i_address = 2'd1;
        push_word(0, 2'b01);
        q_bits.push_back(1'b1);
        q_bits.push_back(1'b0);
        q_bits.push_back(1'b0);
        start_load();
        run_load(1000, 1000, 2'b00, 100, rel);
        chk("latency_err", 32'(rel), 32'(2 * (FW + 1)));
        chk("err_flag", 32'(o_load_err), 1);
        chk("err_ready", 32'(o_sdi_ready), 0);
        chk("err_core_reset", 32'(o_core_reset), 1);
        chk("err_done", 32'(o_load_done), 0);
        chk("err_words", 32'(o_words_loaded), 1);
        chk("err_mem1", 32'(o_data), 0);
        check_sb();
        start_load();
        chk("err_recover_ready", 32'(o_sdi_ready), 1);
        chk("err_recover_flag", 32'(o_load_err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/program_loader.md
# program_loader

Serial program loader and writable instruction store for the paper processor. It sits where the read-only program memory sits today. While loading, it shifts a program into a DEPTH-entry store and holds the core in reset. Once the store is full, it releases the core, which then fetches instructions through the same combinational read port the read-only memory provides.

## Interface

Parameters:
- DEPTH, 4: number of instruction words; power of two.
- AW, 2: address width; log2(DEPTH).
- IW, 2: instruction width in bits.

Ports:
- clk, in, 1: clock; all state changes occur on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- clk_en, in, 1: when low, every register and memory word holds.
- load_start, in, 1: level sampled each enabled edge; requests a (re)load.
- sdi, in, 1: serial program bit, MSB of each word first, word 0 first.
- sdi_valid, in, 1: sdi carries a bit this cycle.
- sdi_ready, out, 1: loader accepts a bit this cycle.
- address, in, AW: fetch address from the program counter.
- data, out, IW: mem[address]; combinational, valid in every state.
- core_reset, out, 1: drives the core's reset; high unless in RUN.
- load_done, out, 1: high in RUN.
- load_err, out, 1: high in ERR.
- words_loaded, out, AW+1: number of words written in the current load.

## Operation

- States: IDLE, SHIFT, WRITE, RUN, ERR. All transitions require clk_en=1.
- IDLE: load_start=1 → SHIFT. On entry, the bit counter, write pointer and words_loaded are cleared.
- SHIFT: sdi_ready=1.
  - A bit is accepted when sdi_valid & sdi_ready & clk_en; it is shifted into the word register LSB-side.
  - When the last bit of the frame is accepted, the next state is WRITE.
  - A frame is IW bits, or IW+1 bits with the macro enabled.
  - sdi_valid=0 stalls with no timeout.
- WRITE: lasts one cycle; sdi_ready=0.
  - The word is written to mem[wr_ptr]; wr_ptr and words_loaded increment.
  - If this was word DEPTH-1 → RUN; otherwise → SHIFT.
- RUN: core_reset=0, load_done=1, sdi_ready=0. load_start=1 → SHIFT with pointers cleared; old contents remain until overwritten.
- ERR: see Configuration. load_start=1 → SHIFT with pointers cleared.
- Ignored inputs:
  - load_start is ignored in SHIFT and WRITE.
  - sdi and sdi_valid are ignored outside SHIFT.
- wr_ptr wraps from DEPTH-1 to 0 on the final write. words_loaded saturates at DEPTH and never wraps.
- There is no write port other than the serial path; address never affects writes.

## Timing

- Reset values:
  - state IDLE; every mem word 0.
  - sdi_ready=0, core_reset=1, load_done=0, load_err=0, words_loaded=0.
  - data = 0 for any address.
- Reset mid-load or mid-run: immediate return to the reset values; the partial program is discarded.
- load_start high at edge E → SHIFT after E; sdi_ready=1 during cycle E+1.
- Latency:
  - With no stalls, word k is written at edge E+(k+1)(F+1), where F is the frame length.
  - For DEPTH=4 and IW=2, core_reset falls and load_done rises after edge E+12.
- data reflects a new word in the cycle after its WRITE edge.
- clk_en low during any state freezes the state, counters and the partially shifted word; the bit on sdi is not accepted.

## Configuration

- PROGRAM_LOADER_PARITY_EN defined:
  - Each frame is IW data bits followed by one parity bit.
  - The XOR of all IW+1 bits must be 0.
  - On mismatch, the WRITE cycle does not write or increment and goes to ERR: load_err=1, sdi_ready=0, core_reset=1, load_done=0.
- PROGRAM_LOADER_PARITY_EN undefined:
  - Frames are IW bits.
  - load_err is tied to 0 and ERR is unreachable.

## Test plan

- Reset behaviour: assert reset asynchronously mid-cycle → all outputs take their reset values before the next edge; data=00 for addresses 0–3.
- Gap-free load (parity off): load_start at edge 0, then bit stream 0,1 | 1,0 | 1,1 | 0,0 → load_done=1 and core_reset=0 after edge 12; data reads 01, 10, 11, 00 at addresses 0–3; words_loaded=4.
- Stalls and clock enable: drop sdi_valid for 3 cycles mid-word 1, then drop clk_en for 2 cycles → completion slips by exactly 5 cycles; contents are identical.
- Reload: from RUN, load_start=1, then load 11,11,11,11 → core_reset=1 from the cycle after load_start until the final write; data at address 3 reads 00 until word 3 is written, then 11.
- Parity error (macro on): second frame sent as 1,0,0 → ERR after that frame; load_err=1; mem[1] unchanged; words_loaded=1; load_start recovers the loader to SHIFT.
- Reset mid-load: assert reset after 2 words are written → mem is all 0, state IDLE, core_reset=1.
